// File: rtl/pwm_pkg.sv
// Shared types for the PWM generator: FSM state encoding.
package pwm_pkg;
  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SINC   = 2'd1,
    ACTIVO = 2'd2,
    DRENAR = 2'd3
  } estado_t;
endpackage

// File: rtl/registro_sombra.sv
// Double-buffered duty register: strobes land in a pending slot and become active
// at the next period boundary; while idle they take effect immediately.
module registro_sombra #(
  parameter int width_counter = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en_reposo,
  input  logic                     carga_duty,
  input  logic                     fin_cuenta,
  input  logic [width_counter-1:0] duty,
  output logic [width_counter-1:0] duty_activo
);
  logic [width_counter-1:0] duty_pend_q, duty_pend_d;
  logic [width_counter-1:0] duty_activo_q, duty_activo_d;
  logic                     pend_q, pend_d;

  always_comb begin
    duty_pend_d   = duty_pend_q;
    duty_activo_d = duty_activo_q;
    pend_d        = pend_q;
    if (fin_cuenta && pend_q) begin
      duty_activo_d = duty_pend_q;
      pend_d        = 1'b0;
    end
    // A strobe coincident with the boundary stays pending for one more period.
    if (carga_duty) begin
      duty_pend_d = duty;
      if (en_reposo) begin
        duty_activo_d = duty;
        pend_d        = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      duty_pend_q   <= '0;
      duty_activo_q <= '0;
      pend_q        <= 1'b0;
    end else begin
      duty_pend_q   <= duty_pend_d;
      duty_activo_q <= duty_activo_d;
      pend_q        <= pend_d;
    end
  end

  assign duty_activo = duty_activo_q;
endmodule

// File: rtl/generador_pwm.sv
// PWM stage behind a variable-modulus counter: burst/continuous run control,
// period counting and registered duty comparison.
module generador_pwm
  import pwm_pkg::*;
#(
  parameter int width_counter = 4,
  parameter int width_pulsos  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [width_counter-1:0] cuenta,
  input  logic                     fin_cuenta,
  input  logic [width_counter-1:0] duty,
  input  logic                     carga_duty,
  input  logic [width_pulsos-1:0]  n_pulsos,
  input  logic                     modo_continuo,
  input  logic                     inicio,
  input  logic                     parar,
  output logic                     pwm_out,
  output logic                     ocupado,
  output logic                     fin_rafaga,
  output logic [width_counter-1:0] duty_activo
);
  estado_t                 estado_q, estado_d;
  logic [width_pulsos-1:0] n_lat_q, n_lat_d;
  logic [width_pulsos-1:0] periodos_q, periodos_d;
  logic                    modo_lat_q, modo_lat_d;
  logic                    pwm_q, pwm_d;
  logic                    fin_q, fin_d;

  registro_sombra #(.width_counter(width_counter)) u_sombra (
    .clock       (clock),
    .reset       (reset),
    .en_reposo   (estado_q == REPOSO),
    .carga_duty  (carga_duty),
    .fin_cuenta  (fin_cuenta),
    .duty        (duty),
    .duty_activo (duty_activo)
  );

  always_comb begin
    estado_d   = estado_q;
    n_lat_d    = n_lat_q;
    modo_lat_d = modo_lat_q;
    periodos_d = periodos_q;
    fin_d      = 1'b0;
    case (estado_q)
      REPOSO: if (inicio) begin
        n_lat_d    = n_pulsos;
        modo_lat_d = modo_continuo;
        // An empty burst completes on the spot without ever leaving idle.
        if (!modo_continuo && n_pulsos == '0) fin_d = 1'b1;
        else                                  estado_d = SINC;
      end
      SINC: begin
        if (parar) begin
          estado_d = REPOSO;
          fin_d    = 1'b1;
        end else if (fin_cuenta) begin
          estado_d   = ACTIVO;
          periodos_d = '0;
        end
      end
      ACTIVO, DRENAR: begin
        if (fin_cuenta) begin
          if (estado_q == DRENAR ||
              (!modo_lat_q && periodos_q == n_lat_q - 1'b1)) begin
            estado_d = REPOSO;
            fin_d    = 1'b1;
          end else if (periodos_q != '1) begin
            periodos_d = periodos_q + 1'b1;
          end
        end
        if (parar && estado_q == ACTIVO && estado_d == ACTIVO) estado_d = DRENAR;
      end
      default: estado_d = REPOSO;
    endcase
    pwm_d = (estado_q == ACTIVO || estado_q == DRENAR) && (cuenta < duty_activo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= REPOSO;
      n_lat_q    <= '0;
      modo_lat_q <= 1'b0;
      periodos_q <= '0;
      pwm_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      n_lat_q    <= n_lat_d;
      modo_lat_q <= modo_lat_d;
      periodos_q <= periodos_d;
      pwm_q      <= pwm_d;
      fin_q      <= fin_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign fin_rafaga = fin_q;
  assign ocupado    = (estado_q != REPOSO);
endmodule
